// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the command sequencer's byte, register-file, ALU and TX-FIFO signals.
// master = sequencer side, slave = the UART/register-file/ALU/FIFO environment.
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    rx_valid;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic                    rf_wr_en;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic                    rf_rd_en;
  logic [DATA_WIDTH-1:0]   rf_rd_data;
  logic                    rf_rd_valid;
  logic [3:0]              alu_fun;
  logic                    alu_en;
  logic                    alu_clk_en;
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    alu_out_valid;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_valid;
  logic                    fifo_full;
  logic                    cmd_err;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           tx_data, tx_valid, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, fifo_full,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           tx_data, tx_valid, cmd_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses UART RX frames into register-file writes/reads and ALU runs,
// and pushes the response bytes into the TX FIFO.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_ctrl_if.master  bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB,
    ALU_FUN, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI
  } state_e;

  state_e                  state_q,      state_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q,    rf_addr_d;
  logic                    rf_wr_en_q,   rf_wr_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    rf_rd_en_q,   rf_rd_en_d;
  logic [3:0]              alu_fun_q,    alu_fun_d;
  logic                    alu_en_q,     alu_en_d;
  logic                    alu_clk_en_q, alu_clk_en_d;
  logic [2*DATA_WIDTH-1:0] result_q,     result_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
  logic                    cmd_err_q,    cmd_err_d;
  logic                    sending;

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    result_d     = result_q;
    tx_data_d    = tx_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    cmd_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_WR:     state_d = WR_ADDR;
            CMD_RD:     state_d = RD_ADDR;
            CMD_ALU_OP: state_d = OPA;
            CMD_ALU:    state_d = ALU_FUN;
            default:    cmd_err_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.rx_valid) begin
          rf_addr_d = bus.rx_data[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.rx_valid) begin
          rf_wr_data_d = bus.rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_valid) begin
          rf_addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.rf_rd_valid) begin
          tx_data_d = bus.rf_rd_data;
          state_d   = SEND_RD;
        end
      end
      OPA: begin
        if (bus.rx_valid) begin
          rf_addr_d    = '0;
          rf_wr_data_d = bus.rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = OPB;
        end
      end
      OPB: begin
        if (bus.rx_valid) begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = bus.rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (bus.rx_valid) begin
          alu_fun_d = bus.rx_data[3:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.alu_out_valid) begin
          result_d  = bus.alu_out;
          tx_data_d = bus.alu_out[DATA_WIDTH-1:0];
          state_d   = SEND_LO;
        end
      end
      SEND_RD: begin
        if (!bus.fifo_full) state_d = IDLE;
      end
      SEND_LO: begin
        if (bus.fifo_full) begin
          tx_data_d = result_q[DATA_WIDTH-1:0];
        end else begin
          tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (!bus.fifo_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    alu_clk_en_d = (state_d == ALU_FUN) || (state_d == ALU_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      alu_clk_en_q <= 1'b0;
      result_q     <= '0;
      tx_data_q    <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      alu_clk_en_q <= alu_clk_en_d;
      result_q     <= result_d;
      tx_data_q    <= tx_data_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // tx_valid is the registered send state gated by the live fifo_full, so the
  // strobe can never land on a full FIFO and each byte is written exactly once.
  assign sending = (state_q == SEND_RD) || (state_q == SEND_LO) || (state_q == SEND_HI);

  always_comb begin
    bus.rf_addr    = rf_addr_q;
    bus.rf_wr_en   = rf_wr_en_q;
    bus.rf_wr_data = rf_wr_data_q;
    bus.rf_rd_en   = rf_rd_en_q;
    bus.alu_fun    = alu_fun_q;
    bus.alu_en     = alu_en_q;
    bus.alu_clk_en = alu_clk_en_q;
    bus.tx_data    = tx_data_q;
    bus.tx_valid   = sending && !bus.fifo_full;
    bus.cmd_err    = cmd_err_q;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: cycle-exact vector table, a mid-frame reset sequence, and
// random frames scored against a frame-level reference model.
module tb_uart_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  uart_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // inf = {rx_valid, rf_rd_valid, alu_out_valid, fifo_full}; rsp feeds rf_rd_data/alu_out
  // outf = {rf_wr_en, rf_rd_en, alu_en, alu_clk_en, tx_valid, cmd_err}
  typedef struct {
    logic [3:0]  inf;
    logic [7:0]  rxd;
    logic [15:0] rsp;
    logic [5:0]  outf;
    logic [3:0]  addr;
    logic [7:0]  wdat;
    logic [3:0]  fun;
    logic [7:0]  txd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] inf, input logic [7:0] rxd, input logic [15:0] rsp,
                     input logic [5:0] outf, input logic [3:0] addr, input logic [7:0] wdat,
                     input logic [3:0] fun, input logic [7:0] txd);
    vec_t v;
    v.inf = inf; v.rxd = rxd; v.rsp = rsp; v.outf = outf;
    v.addr = addr; v.wdat = wdat; v.fun = fun; v.txd = txd;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.rf_addr, bus.rf_wr_en, bus.rf_wr_data, bus.rf_rd_en, bus.alu_fun,
                bus.alu_en, bus.alu_clk_en, bus.tx_data, bus.tx_valid, bus.cmd_err});
  endfunction

  // Environment ALU definition, shared by the responder and the reference model.
  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      4'd5:    return {8'h00, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  // random-phase environment and scoreboards
  logic [7:0]  env_rf [16];
  logic [7:0]  ref_rf [16];
  logic [11:0] act_wr[$], exp_wr[$];
  logic [3:0]  act_rd[$], exp_rd[$];
  logic [3:0]  act_alu[$], exp_alu[$];
  logic [7:0]  act_tx[$], exp_tx[$];
  int          act_err = 0, exp_err = 0;
  int          rd_t = 0, alu_t = 0;
  logic [3:0]  rd_a;
  logic [15:0] alu_r;
  bit          abort = 1'b0;

  task automatic tick_r();
    @(posedge clk); #1;
    bus.rf_rd_valid   = 1'b0;
    bus.alu_out_valid = 1'b0;
    if (bus.rf_wr_en) begin
      env_rf[bus.rf_addr] = bus.rf_wr_data;
      act_wr.push_back({bus.rf_addr, bus.rf_wr_data});
    end
    if (rd_t > 0) begin
      rd_t--;
      if (rd_t == 0) begin bus.rf_rd_valid = 1'b1; bus.rf_rd_data = env_rf[rd_a]; end
    end
    if (bus.rf_rd_en) begin
      act_rd.push_back(bus.rf_addr);
      rd_a = bus.rf_addr;
      rd_t = $urandom_range(1, 3);
    end
    if (alu_t > 0) begin
      alu_t--;
      if (alu_t == 0) begin bus.alu_out_valid = 1'b1; bus.alu_out = alu_r; end
    end
    if (bus.alu_en) begin
      act_alu.push_back(bus.alu_fun);
      alu_r = alu_fn(bus.alu_fun, env_rf[0], env_rf[1]);
      alu_t = $urandom_range(1, 4);
    end
    if (bus.cmd_err) act_err++;
    bus.fifo_full = ($urandom_range(0, 3) == 0);
    #1;
    if (bus.tx_valid) act_tx.push_back(bus.tx_data);
    chk("tx_valid_while_full", 32'(bus.tx_valid & bus.fifo_full), 32'd0);
    chk("alu_en_without_clk_en", 32'(bus.alu_en & ~bus.alu_clk_en), 32'd0);
  endtask

  task automatic send_b(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick_r();
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 1)) tick_r();
  endtask

  // Bytes offered while a response is outstanding must be dropped by the DUT.
  task automatic wait_resp();
    int budget = 0;
    while (act_tx.size() < exp_tx.size() && budget < 100) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.rx_data  = 8'($urandom);
        bus.rx_valid = 1'b1;
      end
      tick_r();
      bus.rx_valid = 1'b0;
      budget++;
    end
    chk("response_timeout", 32'(act_tx.size() < exp_tx.size()), 32'd0);
    if (act_tx.size() < exp_tx.size()) abort = 1'b1;
    tick_r();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a, d, b2, fn;
    logic [15:0] r;

    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    bus.rf_rd_valid = 1'b0; bus.rf_rd_data = '0;
    bus.alu_out_valid = 1'b0; bus.alu_out = '0;
    bus.fifo_full = 1'b0;

    //   inf      rxd    rsp       outf       addr  wdat   fun   txd
    add(4'b1000, 8'hAA, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'h03, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'h5A, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hBB, 16'h0000, 6'b100000, 4'h3, 8'h5A, 4'h0, 8'h00);
    add(4'b1000, 8'h03, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b010000, 4'h3, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0100, 8'h00, 16'h005A, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b000010, 4'h0, 8'h00, 4'h0, 8'h5A);
    add(4'b1000, 8'hCC, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'h10, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'h20, 16'h0000, 6'b100000, 4'h0, 8'h10, 4'h0, 8'h00);
    add(4'b1000, 8'h00, 16'h0000, 6'b100100, 4'h1, 8'h20, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b001100, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hAA, 16'h0000, 6'b000100, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1010, 8'h77, 16'h0030, 6'b000100, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b000010, 4'h0, 8'h00, 4'h0, 8'h30);
    add(4'b0000, 8'h00, 16'h0000, 6'b000010, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hDD, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'h02, 16'h0000, 6'b000100, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b001100, 4'h0, 8'h00, 4'h2, 8'h00);
    add(4'b0010, 8'h00, 16'h1234, 6'b000100, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0001, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b1001, 8'hBB, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b0001, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b0001, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b0001, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b0000, 8'h00, 16'h0000, 6'b000010, 4'h0, 8'h00, 4'h0, 8'h34);
    add(4'b0001, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h12);
    add(4'b0000, 8'h00, 16'h0000, 6'b000010, 4'h0, 8'h00, 4'h0, 8'h12);
    add(4'b1000, 8'h77, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hAA, 16'h0000, 6'b000001, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hF7, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b1000, 8'hC3, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b100000, 4'h7, 8'hC3, 4'h0, 8'h00);
    add(4'b0000, 8'h00, 16'h0000, 6'b000000, 4'h0, 8'h00, 4'h0, 8'h00);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("reset_outputs", all_outs(), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      bus.rx_valid      = tbl[i].inf[3];
      bus.rx_data       = tbl[i].rxd;
      bus.rf_rd_valid   = tbl[i].inf[2];
      bus.rf_rd_data    = tbl[i].rsp[7:0];
      bus.alu_out_valid = tbl[i].inf[1];
      bus.alu_out       = tbl[i].rsp;
      bus.fifo_full     = tbl[i].inf[0];
      #1;
      chk($sformatf("vec%0d strobes", i),
          32'({bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.alu_clk_en, bus.tx_valid, bus.cmd_err}),
          32'(tbl[i].outf));
      if (tbl[i].outf[5] || tbl[i].outf[4])
        chk($sformatf("vec%0d rf_addr", i), 32'(bus.rf_addr), 32'(tbl[i].addr));
      if (tbl[i].outf[5])
        chk($sformatf("vec%0d rf_wr_data", i), 32'(bus.rf_wr_data), 32'(tbl[i].wdat));
      if (tbl[i].outf[3])
        chk($sformatf("vec%0d alu_fun", i), 32'(bus.alu_fun), 32'(tbl[i].fun));
      if (tbl[i].outf[1] || tbl[i].txd != 8'h00)
        chk($sformatf("vec%0d tx_data", i), 32'(bus.tx_data), 32'(tbl[i].txd));
    end

    // reset in the middle of a 0xCC frame, then a normal write
    @(posedge clk); #1 bus.rx_valid = 1'b1; bus.rx_data = 8'hCC;
    @(posedge clk); #1 bus.rx_data = 8'h05;
    @(posedge clk); #1 bus.rx_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    #1 chk("midframe_reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("after_reset_outputs", all_outs(), 32'd0);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
    @(posedge clk); #1 bus.rx_data = 8'h02;
    @(posedge clk); #1 bus.rx_data = 8'h66;
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    #1 chk("post_reset_write", 32'({bus.rf_wr_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en, bus.alu_clk_en}),
           32'({1'b1, 4'h2, 8'h66, 1'b0, 1'b0}));
    @(posedge clk); #2;
    chk("post_reset_single_strobe", 32'({bus.rf_wr_en, bus.rf_rd_en, bus.tx_valid, bus.cmd_err}), 32'd0);

    // random frames against the frame-level reference model
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin env_rf[k] = 8'h00; ref_rf[k] = 8'h00; end

    for (int f = 0; f < 60 && !abort; f++) begin
      a  = 8'($urandom);
      d  = 8'($urandom);
      b2 = 8'($urandom);
      fn = 8'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          exp_wr.push_back({a[3:0], d});
          ref_rf[a[3:0]] = d;
          send_b(8'hAA); send_b(a); send_b(d);
        end
        1: begin
          exp_rd.push_back(a[3:0]);
          exp_tx.push_back(ref_rf[a[3:0]]);
          send_b(8'hBB); send_b(a);
          wait_resp();
        end
        2: begin
          exp_wr.push_back({4'h0, d});
          exp_wr.push_back({4'h1, b2});
          ref_rf[0] = d;
          ref_rf[1] = b2;
          exp_alu.push_back(fn[3:0]);
          r = alu_fn(fn[3:0], d, b2);
          exp_tx.push_back(r[7:0]);
          exp_tx.push_back(r[15:8]);
          send_b(8'hCC); send_b(d); send_b(b2); send_b(fn);
          wait_resp();
        end
        3: begin
          exp_alu.push_back(fn[3:0]);
          r = alu_fn(fn[3:0], ref_rf[0], ref_rf[1]);
          exp_tx.push_back(r[7:0]);
          exp_tx.push_back(r[15:8]);
          send_b(8'hDD); send_b(fn);
          wait_resp();
        end
        default: begin
          while (a inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) a = 8'($urandom);
          exp_err++;
          send_b(a);
        end
      endcase
    end
    repeat (3) tick_r();

    chk("rand_wr_count", 32'(act_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      chk($sformatf("rand_wr%0d", i), 32'(act_wr[i]), 32'(exp_wr[i]));
    chk("rand_rd_count", 32'(act_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk($sformatf("rand_rd%0d", i), 32'(act_rd[i]), 32'(exp_rd[i]));
    chk("rand_alu_count", 32'(act_alu.size()), 32'(exp_alu.size()));
    for (int i = 0; i < exp_alu.size() && i < act_alu.size(); i++)
      chk($sformatf("rand_alu%0d", i), 32'(act_alu[i]), 32'(exp_alu[i]));
    chk("rand_tx_count", 32'(act_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      chk($sformatf("rand_tx%0d", i), 32'(act_tx[i]), 32'(exp_tx[i]));
    chk("rand_cmd_err_count", 32'(act_err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver/transmitter pair and the system's register file and ALU. It parses byte frames arriving from the UART RX path and performs register writes, register reads and ALU operations. Response bytes are pushed into the TX-side FIFO, which feeds the UART TX path. It runs entirely in the reference (system) clock domain; RX bytes and FIFO status arrive already synchronized.

## Interface
- DATA_WIDTH, 8, byte/register width
- ADDR_WIDTH, 4, register-file address width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  DATA_WIDTH  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle pulse per received byte
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_en  out  1  one-cycle read strobe
- rf_rd_data  in  DATA_WIDTH  read data, valid with rf_rd_valid
- rf_rd_valid  in  1  read-data-valid pulse
- alu_fun  out  4  ALU function code
- alu_en  out  1  one-cycle ALU start strobe
- alu_clk_en  out  1  ALU clock-gate enable
- alu_out  in  2*DATA_WIDTH  ALU result, valid with alu_out_valid
- alu_out_valid  in  1  ALU result-valid pulse
- tx_data  out  DATA_WIDTH  response byte to TX FIFO
- tx_valid  out  1  FIFO write strobe; asserted only when fifo_full=0
- fifo_full  in  1  TX FIFO full
- cmd_err  out  1  one-cycle pulse on unknown command byte

## Operation
- Frames, first byte = command:
  - 0xAA: addr, data. Writes data to rf[addr].
  - 0xBB: addr. Reads rf[addr] and sends 1 response byte.
  - 0xCC: A, B, fun. Writes A to rf[0] and B to rf[1], then runs the ALU and sends 2 response bytes.
  - 0xDD: fun. Runs the ALU on the current rf[0]/rf[1] and sends 2 response bytes.
- Address bytes use rx_data[ADDR_WIDTH-1:0]; upper bits are ignored.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI.
- IDLE: rx_valid with 0xAA, 0xBB, 0xCC or 0xDD goes to WR_ADDR, RD_ADDR, OPA or ALU_FUN respectively. Any other byte pulses cmd_err and stays in IDLE.
- WR_ADDR: latch addr, go to WR_DATA. WR_DATA: on rx_valid, issue the write and go to IDLE.
- RD_ADDR: on rx_valid, issue rf_rd_en and go to RD_WAIT. RD_WAIT: on rf_rd_valid, latch rf_rd_data and go to SEND_RD.
- OPA: on rx_valid, write rf[0] and go to OPB. OPB: on rx_valid, write rf[1] and go to ALU_FUN.
- ALU_FUN: on rx_valid, latch fun[3:0], pulse alu_en, go to ALU_WAIT. ALU_WAIT: on alu_out_valid, latch the full result and go to SEND_LO.
- SEND_RD sends the latched read byte, then goes to IDLE.
- SEND_LO sends result[DATA_WIDTH-1:0] and goes to SEND_HI. SEND_HI sends result[2*DATA_WIDTH-1:DATA_WIDTH] and goes to IDLE.
- Each SEND state holds while fifo_full=1, with tx_valid=0 and tx_data stable.
- rx_valid in RD_WAIT, ALU_WAIT or any SEND state: byte is dropped, no state change, no cmd_err.
- Each response byte is written exactly once; no duplicates, no drops.
- alu_clk_en=1 in ALU_FUN and ALU_WAIT, otherwise 0.

## Timing
- All outputs registered.
- Reset values: every output is 0. State=IDLE, latched addr/data/result cleared.
- rst in any state, mid-frame included, returns to IDLE the next cycle. The partial frame is discarded with no further strobes.
- Write latency: rf_wr_en is high the cycle after the rx_valid of the data byte, with rf_addr and rf_wr_data valid in that same cycle.
- Read: rf_rd_en goes high 1 cycle after the addr-byte rx_valid. tx_valid goes high 1 cycle after rf_rd_valid, provided fifo_full=0.
- ALU: alu_en goes high 1 cycle after the fun-byte rx_valid, with alu_fun valid in that cycle. First tx_valid comes 1 cycle after alu_out_valid; the second comes on the next cycle in which fifo_full=0.
- fifo_full is sampled in the same cycle tx_valid would assert; tx_valid never coincides with fifo_full=1.
- A new command byte is accepted in the cycle immediately after returning to IDLE.

## Test plan
- Reset: drive rst for 2 cycles mid-frame (after 0xCC, 0x05) → all outputs 0, state IDLE; next 0xAA frame operates normally.
- Write: 0xAA, 0x03, 0x5A → single rf_wr_en pulse with rf_addr=3, rf_wr_data=0x5A, 1 cycle after the last byte; no tx_valid.
- Read: 0xBB, 0x03; model returns 0x5A 2 cycles after rf_rd_en → rf_rd_en with rf_addr=3; one tx_valid with tx_data=0x5A.
- ALU with operands: 0xCC, 0x10, 0x20, 0x0; ALU returns 0x0030 → rf writes rf[0]=0x10 and rf[1]=0x20; alu_en with alu_fun=0; alu_clk_en high over ALU_FUN..ALU_WAIT; tx bytes 0x30 then 0x00.
- Backpressure: 0xDD, 0x2; result 0x1234; fifo_full held high 5 cycles → no tx_valid while full; then 0x34 followed by 0x12, each exactly once.
- Errors/drops: byte 0x77 in IDLE → one cmd_err pulse, state IDLE. Extra bytes in ALU_WAIT → ignored; response unchanged.
